// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The FSM encodings are fixed so that debug tooling can decode the state directly.
package imem_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      S_BOOT   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Circular prefetch FIFO holding {instruction, pc} pairs.
// A flush empties the queue and takes priority over a push in the same cycle.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int W     = 64,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [CNT_W-1:0] count,
   output logic [W-1:0]     head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = ptr_inc(tail_q);
         if (pop)  head_d = ptr_inc(head_q);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[tail_q] <= din;
   end

   assign count = count_q;
   assign head  = mem_q[head_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, addresses the combinational ROM,
// and streams {instr, pc} to decode through a small prefetch queue.
module imem_fetch_ctrl
   import imem_fetch_ctrl_pkg::*;
#(
   parameter int          ADDR_W   = 6,
   parameter int          DATA_W   = 32,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_a,
   input  logic [DATA_W-1:0] imem_rd,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              halt,
   output logic [DATA_W-1:0] instr,
   output logic [31:0]       instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       fetch_pc,
   output logic              halted
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = DATA_W + 32;

   fetch_state_e      state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]  q_count;
   logic [ENT_W-1:0]  q_head;
   logic              push, pop;

   assign instr_valid = (q_count != '0);
   assign pop         = instr_valid && instr_ready;
   // A pop frees a slot in the same cycle, which is what sustains 1 instr/cycle when full.
   assign push        = (state_q == S_RUN) && !redirect && !halt &&
                        ((q_count < CNT_W'(DEPTH)) || pop);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         state_d    = S_RUN;
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         case (state_q)
            S_BOOT:   state_d = S_RUN;
            S_RUN:    if (halt) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_BOOT;
         endcase
         if (push) fetch_pc_d = fetch_pc_q + PC_INC;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .W     (ENT_W),
      .CNT_W (CNT_W)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .din   ({imem_rd, fetch_pc_q}),
      .count (q_count),
      .head  (q_head)
   );

   // Gate the head with valid so an empty queue presents zeros rather than stale storage.
   assign instr    = instr_valid ? q_head[ENT_W-1:32] : '0;
   assign instr_pc = instr_valid ? q_head[31:0]       : '0;
   assign imem_a   = fetch_pc_q[ADDR_W+1:2];
   assign fetch_pc = fetch_pc_q;
   assign halted   = (state_q == S_HALTED) && !instr_valid;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a ROM holding word i = i*0x11.
// Each step advances one clock and samples 1 time unit after the rising edge.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  imem_a;
   logic [31:0] imem_rd;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] fetch_pc;
   logic        halted;

   int passed = 0;
   int total  = 0;
   int n104   = 0;

   always #5 clk = ~clk;

   assign imem_rd = 32'(imem_a) * 32'h11;

   imem_fetch_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .imem_a      (imem_a),
      .imem_rd     (imem_rd),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .fetch_pc    (fetch_pc),
      .halted      (halted)
   );

   // Counts how many times the word at 0x104 is handed to decode.
   always @(posedge clk) begin
      if (instr_valid && instr_ready && instr_pc == 32'h104) n104 <= n104 + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] word);
      check({tag, "_valid"}, 32'(instr_valid), 32'd1);
      check({tag, "_pc"}, instr_pc, pc);
      check({tag, "_instr"}, instr, word);
   endtask

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", instr_pc, 32'h0);
      check("rst_fetch_pc", fetch_pc, 32'h0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_imem_a", 32'(imem_a), 32'd0);

      // Streaming from boot
      reset = 1'b0; instr_ready = 1'b1;
      tick();
      check("boot_valid", 32'(instr_valid), 32'd0);
      tick();
      check_head("s0", 32'h0, 32'h00);
      tick();
      check_head("s1", 32'h4, 32'h11);
      tick();
      check_head("s2", 32'h8, 32'h22);
      check("s2_fetch_pc", fetch_pc, 32'h0C);

      // Back-pressure: queue fills to 2, fetch PC and ROM address hold
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_head("stall", 32'h8, 32'h22);
         check("stall_fetch_pc", fetch_pc, 32'h10);
         check("stall_imem_a", 32'(imem_a), 32'd4);
      end
      instr_ready = 1'b1;
      tick();
      check_head("res0", 32'h0C, 32'h33);
      tick();
      check_head("res1", 32'h10, 32'h44);
      tick();
      check_head("res2", 32'h14, 32'h55);

      // Redirect with a full queue; target low bits are dropped
      instr_ready = 1'b0;
      tick();
      redirect = 1'b1; redirect_pc = 32'h2E;
      tick();
      check("redir_valid", 32'(instr_valid), 32'd0);
      check("redir_fetch_pc", fetch_pc, 32'h2C);
      check("redir_imem_a", 32'(imem_a), 32'd11);
      redirect = 1'b0; instr_ready = 1'b1;
      tick();
      check_head("tgt0", 32'h2C, 32'hBB);
      tick();
      check_head("tgt1", 32'h30, 32'hCC);

      // Halt with two entries queued, then drain
      instr_ready = 1'b0;
      tick();
      halt = 1'b1;
      tick();
      check("halt_halted_busy", 32'(halted), 32'd0);
      check("halt_fetch_pc", fetch_pc, 32'h38);
      instr_ready = 1'b1;
      check_head("drain0", 32'h30, 32'hCC);
      tick();
      check_head("drain1", 32'h34, 32'hDD);
      tick();
      check("drained_valid", 32'(instr_valid), 32'd0);
      check("drained_halted", 32'(halted), 32'd1);
      tick();
      check("halted_hold", 32'(halted), 32'd1);
      check("halted_fetch_pc", fetch_pc, 32'h38);

      // Redirect together with halt leaves HALTED; 0x100 wraps to ROM word 0
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      check("rh_halted", 32'(halted), 32'd0);
      check("rh_valid", 32'(instr_valid), 32'd0);
      check("rh_fetch_pc", fetch_pc, 32'h100);
      check("rh_imem_a", 32'(imem_a), 32'd0);
      redirect = 1'b0; halt = 1'b0;
      tick();
      check_head("wrap0", 32'h100, 32'h00);
      tick();
      check_head("wrap1", 32'h104, 32'h11);

      // Redirect in the same cycle as an accepted transfer
      redirect = 1'b1; redirect_pc = 32'h20;
      tick();
      redirect = 1'b0;
      check("rx_valid", 32'(instr_valid), 32'd0);
      check("rx_fetch_pc", fetch_pc, 32'h20);
      tick();
      check_head("rx_tgt", 32'h20, 32'h88);
      check("rx_once", 32'(n104), 32'd1);

      // Reset during a full-queue stall
      instr_ready = 1'b0;
      tick();
      tick();
      check("full_fetch_pc", fetch_pc, 32'h28);
      check_head("full_head", 32'h20, 32'h88);
      reset = 1'b1;
      tick();
      check("mid_rst_valid", 32'(instr_valid), 32'd0);
      check("mid_rst_fetch_pc", fetch_pc, 32'h0);
      check("mid_rst_instr", instr, 32'h0);
      check("mid_rst_pc", instr_pc, 32'h0);
      reset = 1'b0; instr_ready = 1'b1;
      tick();
      check("reboot_valid", 32'(instr_valid), 32'd0);
      tick();
      check_head("reboot0", 32'h0, 32'h00);
      tick();
      check_head("reboot1", 32'h4, 32'h11);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
